// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating counters, redirect generation and stats
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_bp_en,
    input  logic [XLEN-1:0]   i_if_pc,
    output logic              o_pred_taken,
    output logic [XLEN-1:0]   o_pred_target,
    input  logic              i_upd_valid,
    input  logic              i_upd_uncond,
    input  logic [XLEN-1:0]   i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [XLEN-1:0]   i_upd_target,
    input  logic              i_upd_pred_taken,
    input  logic [XLEN-1:0]   i_upd_pred_tgt,
    output logic              o_redirect,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic [STAT_W-1:0] o_br_cnt,
    output logic [STAT_W-1:0] o_miss_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    logic              r_valid [ENTRIES];
    logic [TAG_W-1:0]  r_tag   [ENTRIES];
    logic [XLEN-1:0]   r_tgt   [ENTRIES];
    logic [CTR_W-1:0]  r_ctr   [ENTRIES];
    logic [STAT_W-1:0] r_br, r_miss;
    logic [IDX_W-1:0]  w_idx, w_uidx;
    logic [TAG_W-1:0]  w_tag, w_utag;
    logic              w_hit, w_uhit, w_miss;
    logic [CTR_W-1:0]  w_uctr, w_inc, w_dec;
    always_comb begin
        w_idx         = i_if_pc[IDX_W+1:2];
        w_tag         = i_if_pc[IDX_W+2 +: TAG_W];
        w_uidx        = i_upd_pc[IDX_W+1:2];
        w_utag        = i_upd_pc[IDX_W+2 +: TAG_W];
        w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_uhit        = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
        o_pred_taken  = i_bp_en && w_hit && r_ctr[w_idx][CTR_W-1];
        o_pred_target = o_pred_taken ? r_tgt[w_idx] : '0;
        w_uctr        = r_ctr[w_uidx];
        w_inc         = (w_uctr == CTR_MAX) ? w_uctr : w_uctr + CTR_W'(1);
        w_dec         = (w_uctr == '0) ? w_uctr : w_uctr - CTR_W'(1);
        w_miss        = i_upd_valid && ((i_upd_taken != i_upd_pred_taken) ||
                        (i_upd_taken && i_upd_pred_taken && (i_upd_target != i_upd_pred_tgt)));
        o_redirect    = w_miss;
        o_redirect_pc = w_miss ? (i_upd_taken ? i_upd_target : i_upd_pc + XLEN'(4)) : '0;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_tgt[i]   <= '0;
                r_ctr[i]   <= CTR_WNT;
            end
            r_br   <= '0;
            r_miss <= '0;
        end else if (i_upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= i_upd_taken ? (i_upd_uncond ? CTR_MAX : w_inc) : w_dec;
                if (i_upd_taken) r_tgt[w_uidx] <= i_upd_target;
            end else if (i_upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= i_upd_target;
                r_ctr[w_uidx]   <= i_upd_uncond ? CTR_MAX : CTR_WT;
            end
            if (r_br != '1) r_br <= r_br + STAT_W'(1);
            if (w_miss && r_miss != '1) r_miss <= r_miss + STAT_W'(1);
        end
    end
    assign o_br_cnt   = r_br;
    assign o_miss_cnt = r_miss;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor (default and STAT_W=4 instances)
module tb_branch_predictor;
    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;
    logic        clk = 1'b0;
    logic        resetn;
    logic        i_bp_en;
    logic [31:0] i_if_pc;
    logic        i_upd_valid, i_upd_uncond, i_upd_taken, i_upd_pred_taken;
    logic [31:0] i_upd_pc, i_upd_target, i_upd_pred_tgt;
    logic        o_pred_taken, o_redirect;
    logic [31:0] o_pred_target, o_redirect_pc, o_br_cnt, o_miss_cnt;
    logic        s_pred_taken, s_redirect;
    logic [31:0] s_pred_target, s_redirect_pc;
    logic [3:0]  s_br_cnt, s_miss_cnt;
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_br = 0;
    int          m_miss = 0;

    always #5 clk = ~clk;

    branch_predictor u_dut (
        .clk(clk), .resetn(resetn), .i_bp_en(i_bp_en), .i_if_pc(i_if_pc),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
        .i_upd_valid(i_upd_valid), .i_upd_uncond(i_upd_uncond), .i_upd_pc(i_upd_pc),
        .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
        .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_tgt(i_upd_pred_tgt),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_br_cnt(o_br_cnt), .o_miss_cnt(o_miss_cnt)
    );

    branch_predictor #(.STAT_W(4)) u_small (
        .clk(clk), .resetn(resetn), .i_bp_en(i_bp_en), .i_if_pc(i_if_pc),
        .o_pred_taken(s_pred_taken), .o_pred_target(s_pred_target),
        .i_upd_valid(i_upd_valid), .i_upd_uncond(i_upd_uncond), .i_upd_pc(i_upd_pc),
        .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
        .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_tgt(i_upd_pred_tgt),
        .o_redirect(s_redirect), .o_redirect_pc(s_redirect_pc),
        .o_br_cnt(s_br_cnt), .o_miss_cnt(s_miss_cnt)
    );

    function automatic string kname(input int k);
        return k == 0 ? "pred_taken" : k == 1 ? "pred_target" : k == 2 ? "redirect" :
               k == 3 ? "redirect_pc" : k == 4 ? "br_cnt" : k == 5 ? "miss_cnt" :
               k == 6 ? "small_br_cnt" : "small_miss_cnt";
    endfunction

    function automatic logic [31:0] observe(input int k);
        return k == 0 ? {31'd0, o_pred_taken} : k == 1 ? o_pred_target :
               k == 2 ? {31'd0, o_redirect} : k == 3 ? o_redirect_pc :
               k == 4 ? o_br_cnt : k == 5 ? o_miss_cnt :
               k == 6 ? {28'd0, s_br_cnt} : {28'd0, s_miss_cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(kname(e.kind), observe(e.kind), e.val);
        end
    endtask

    task automatic push_counts();
        push(4, m_br);
        push(5, m_miss);
        push(6, m_br > 15 ? 15 : m_br);
        push(7, m_miss > 15 ? 15 : m_miss);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        i_if_pc = pc;
        #2;
        push(0, {31'd0, tk});
        push(1, tgt);
        drain();
    endtask

    task automatic drive_upd(input logic unc, input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        i_upd_valid      = 1'b1;
        i_upd_uncond     = unc;
        i_upd_pc         = pc;
        i_upd_taken      = tk;
        i_upd_target     = tgt;
        i_upd_pred_taken = ptk;
        i_upd_pred_tgt   = ptgt;
    endtask

    task automatic finish_upd(input logic redir, input logic [31:0] rpc);
        #1;
        push(2, {31'd0, redir});
        push(3, rpc);
        drain();
        @(posedge clk);
        #1;
        i_upd_valid = 1'b0;
        m_br++;
        m_miss += redir ? 1 : 0;
        push_counts();
        drain();
    endtask

    task automatic upd(input logic unc, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt, input logic redir, input logic [31:0] rpc);
        drive_upd(unc, pc, tk, tgt, ptk, ptgt);
        finish_upd(redir, rpc);
    endtask

    initial begin
        resetn = 1'b0;
        i_bp_en = 1'b1;
        i_if_pc = 32'h0;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        i_upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        // reset state
        lookup(32'h40, 1'b0, 32'h0);
        push_counts();
        drain();
        // first allocation mispredicts, then predicts taken
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40, 1'b1, 32'h80);
        // decrement toward 0 and saturate there
        upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h44);
        lookup(32'h40, 1'b0, 32'h0);
        upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40, 1'b0, 32'h0);
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40, 1'b1, 32'h80);
        // aliasing at idx 0 with a different tag
        lookup(32'h80, 1'b0, 32'h0);
        upd(1'b0, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
        lookup(32'h80, 1'b1, 32'h300);
        lookup(32'h40, 1'b0, 32'h0);
        // read-before-write on the same index
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        drive_upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40, 1'b1, 32'h80);
        finish_upd(1'b1, 32'h44);
        lookup(32'h40, 1'b0, 32'h0);
        // prediction disabled while training continues
        i_bp_en = 1'b0;
        upd(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
        lookup(32'h40, 1'b0, 32'h0);
        i_bp_en = 1'b1;
        lookup(32'h40, 1'b1, 32'h80);
        // unconditional jump allocates at max confidence
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h180, 1'b1, 32'h200);
        upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
        lookup(32'h100, 1'b1, 32'h200);
        upd(1'b0, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        // idle cycle: no redirect, counters hold
        #1;
        push(2, 32'h0);
        push(3, 32'h0);
        drain();
        @(posedge clk);
        #1;
        push_counts();
        drain();
        // counter saturation on the STAT_W=4 instance
        for (int i = 0; i < 20; i++)
            upd(1'b0, 32'h600 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        // reset with an update pending discards it
        drive_upd(1'b0, 32'h700, 1'b1, 32'h900, 1'b0, 32'h0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        i_upd_valid = 1'b0;
        m_br = 0;
        m_miss = 0;
        push_counts();
        drain();
        lookup(32'h700, 1'b0, 32'h0);
        lookup(32'h100, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
